// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the data-memory load/store path.
//   - LS_* size encodings as produced by the instruction decoder
//   - ls_state_e: transaction state of the load/store unit
//   - DEFAULT_TIMEOUT_CYCLES / DEFAULT_CNT_W: acknowledge timeout defaults
//   - helpers for alignment checking and byte-enable generation
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam logic [1:0] LS_BYTE    = 2'b00;
    localparam logic [1:0] LS_HALF    = 2'b01;
    localparam logic [1:0] LS_WORD    = 2'b10;
    localparam logic [1:0] LS_ILLEGAL = 2'b11;

    // Cycles to wait for an acknowledge before raising a bus error (>= 1).
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;
    // Counter width; 2**DEFAULT_CNT_W must exceed the timeout.
    localparam int DEFAULT_CNT_W          = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ls_state_e;

    // An access is rejected if its size is illegal or it straddles its
    // natural alignment boundary.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        return (size == LS_ILLEGAL)
            || ((size == LS_HALF) && off[0])
            || ((size == LS_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] off);
        logic [3:0] be;
        case (size)
            LS_BYTE: be = 4'b0001 << off;
            LS_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_store_unit_align_ext.sv
// ---------------------------------------------------------------------------
// load_align_ext
// Purely combinational extraction of a byte/half/word from a 32-bit read
// word, followed by sign or zero extension to 32 bits.
// Ports:
//   off_in       byte offset within the word (addr[1:0])
//   size_in      LS_BYTE / LS_HALF / LS_WORD
//   unsigned_in  1 = zero-extend, 0 = sign-extend
//   rdata_in     raw read word from the memory port
//   data_out     aligned, extended result
// ---------------------------------------------------------------------------
module load_align_ext
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  off_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [31:0] rdata_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        byte_sel  = rdata_in[{off_in, 3'b000} +: 8];
        // Halves are only ever naturally aligned, so off[1] picks the half.
        half_sel  = rdata_in[{off_in[1], 4'b0000} +: 16];
        byte_sign = ~unsigned_in & byte_sel[7];
        half_sign = ~unsigned_in & half_sel[15];
        case (size_in)
            LS_BYTE: data_out = {{24{byte_sign}}, byte_sel};
            LS_HALF: data_out = {{16{half_sign}}, half_sel};
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Data-memory side of the load/store path. Accepts one memory instruction at
// a time from execute, runs a req/ack transaction on the data-memory port,
// returns extended load data, and reports misaligned accesses and
// acknowledge timeouts.
// Ports:
//   clk_in, rst_n_in                 clock, async active-low reset
//   ls_valid_in, is_load_in,
//   is_store_in, load_size_in,
//   load_unsigned_in, addr_in,
//   store_data_in                    request from execute
//   flush_in                         pipeline flush/trap
//   ls_ready_out, stall_out          unit idle / pipeline stall
//   dmem_req_out, dmem_we_out,
//   dmem_addr_out, dmem_be_out,
//   dmem_wdata_out                   memory request (held until ack)
//   dmem_ack_in, dmem_rdata_in       memory response
//   load_data_out, load_valid_out    load result (valid pulse)
//   store_done_out                   store completion pulse
//   misaligned_out, bus_err_out      fault pulses to trap logic
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        ls_valid_in,
    input  logic        is_load_in,
    input  logic        is_store_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        flush_in,
    output logic        ls_ready_out,
    output logic        stall_out,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [3:0]  dmem_be_out,
    output logic [31:0] dmem_wdata_out,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        store_done_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ls_state_e         state_q, state_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_pending_q, flush_pending_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              store_done_q, store_done_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q, bus_err_d;

    logic              accept;
    logic              suppress;
    logic [31:0]       wdata_lanes;
    logic [31:0]       load_ext;

    // Store data replication: every byte lane carries the byte that belongs
    // there for the given size, so memory only needs the byte enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wdata_lane
        assign wdata_lanes[8*gi +: 8] =
            (load_size_in == LS_BYTE) ? store_data_in[7:0] :
            (load_size_in == LS_HALF) ? store_data_in[8*(gi % 2) +: 8] :
                                        store_data_in[8*gi +: 8];
    end

    load_align_ext u_align_ext (
        .off_in      (off_q),
        .size_in     (size_q),
        .unsigned_in (unsigned_q),
        .rdata_in    (dmem_rdata_in),
        .data_out    (load_ext)
    );

    // ready_q also gates acceptance: after a transaction ends the unit spends
    // one IDLE cycle delivering its result before taking the next request.
    assign accept = ls_valid_in & (is_load_in | is_store_in) & ~flush_in & ready_q;

    always_comb begin
        state_d         = state_q;
        ready_d         = ready_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        off_d           = off_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        load_data_d     = load_data_q;
        load_valid_d    = 1'b0;
        store_done_d    = 1'b0;
        misaligned_d    = 1'b0;
        bus_err_d       = 1'b0;
        suppress        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!ready_q) begin
                    ready_d = 1'b1;
                end else if (accept) begin
                    if (is_misaligned(load_size_in, addr_in[1:0])) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d         = ST_BUSY;
                        ready_d         = 1'b0;
                        req_d           = 1'b1;
                        we_d            = is_store_in;
                        addr_d          = {addr_in[31:2], 2'b00};
                        be_d            = byte_enables(load_size_in, addr_in[1:0]);
                        wdata_d         = wdata_lanes;
                        size_d          = load_size_in;
                        unsigned_d      = load_unsigned_in;
                        off_d           = addr_in[1:0];
                        cnt_d           = '0;
                        flush_pending_d = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                // A flush never cancels the bus transaction; it only hides
                // the outcome from the pipeline.
                suppress = flush_pending_q | flush_in;
                if (flush_in) begin
                    flush_pending_d = 1'b1;
                end
                if (dmem_ack_in) begin
                    state_d         = ST_IDLE;
                    req_d           = 1'b0;
                    cnt_d           = '0;
                    flush_pending_d = 1'b0;
                    if (we_q) begin
                        store_done_d = ~suppress;
                    end else if (!suppress) begin
                        load_valid_d = 1'b1;
                        load_data_d  = load_ext;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d         = ST_IDLE;
                    req_d           = 1'b0;
                    cnt_d           = '0;
                    flush_pending_d = 1'b0;
                    bus_err_d       = ~suppress;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q         <= ST_IDLE;
            ready_q         <= 1'b1;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            be_q            <= '0;
            wdata_q         <= '0;
            size_q          <= LS_BYTE;
            unsigned_q      <= 1'b0;
            off_q           <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            load_data_q     <= '0;
            load_valid_q    <= 1'b0;
            store_done_q    <= 1'b0;
            misaligned_q    <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            be_q            <= be_d;
            wdata_q         <= wdata_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            off_q           <= off_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            load_data_q     <= load_data_d;
            load_valid_q    <= load_valid_d;
            store_done_q    <= store_done_d;
            misaligned_q    <= misaligned_d;
            bus_err_q       <= bus_err_d;
        end
    end

    assign ls_ready_out   = ready_q;
    assign stall_out      = ~ready_q;
    assign dmem_req_out   = req_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = addr_q;
    assign dmem_be_out    = be_q;
    assign dmem_wdata_out = wdata_q;
    assign load_data_out  = load_data_q;
    assign load_valid_out = load_valid_q;
    assign store_done_out = store_done_q;
    assign misaligned_out = misaligned_q;
    assign bus_err_out    = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit (timeout shortened to 4 cycles).
// Inputs change and outputs are observed on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, is_load, is_store, load_unsigned, flush;
    logic [1:0]  load_size;
    logic [31:0] addr, store_data;
    logic        ls_ready, stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic [3:0]  dmem_be;
    logic        dmem_ack, load_valid, store_done, misaligned, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .ls_valid_in      (ls_valid),
        .is_load_in       (is_load),
        .is_store_in      (is_store),
        .load_size_in     (load_size),
        .load_unsigned_in (load_unsigned),
        .addr_in          (addr),
        .store_data_in    (store_data),
        .flush_in         (flush),
        .ls_ready_out     (ls_ready),
        .stall_out        (stall),
        .dmem_req_out     (dmem_req),
        .dmem_we_out      (dmem_we),
        .dmem_addr_out    (dmem_addr),
        .dmem_be_out      (dmem_be),
        .dmem_wdata_out   (dmem_wdata),
        .dmem_ack_in      (dmem_ack),
        .dmem_rdata_in    (dmem_rdata),
        .load_data_out    (load_data),
        .load_valid_out   (load_valid),
        .store_done_out   (store_done),
        .misaligned_out   (misaligned),
        .bus_err_out      (bus_err)
    );

    task automatic drive_req(input logic ld, input logic st, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] d);
        ls_valid = 1'b1; is_load = ld; is_store = st; load_size = sz;
        load_unsigned = uns; addr = a; store_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ls_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        load_size = 2'b00; load_unsigned = 1'b0; addr = '0; store_data = '0;
        flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ls_ready, stall, dmem_req, dmem_we} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 1000", {ls_ready, stall, dmem_req, dmem_we});
        end
        checks++;
        if ({load_valid, store_done, misaligned, bus_err} !== 4'b0000 || load_data !== 32'h0) begin
            errors++; $display("FAIL reset_pulses: got %b data %h want 0000 data 0",
                               {load_valid, store_done, misaligned, bus_err}, load_data);
        end
        $display("reset: ready=%b req=%b", ls_ready, dmem_req);
    endtask

    // Store held wait_cycles cycles before ack.
    task automatic test_store(input string name, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input int wait_cycles);
        drive_req(1'b0, 1'b1, sz, 1'b0, a, d);
        @(negedge clk);
        ls_valid = 1'b0;
        checks++;
        if ({dmem_req, dmem_we, stall} !== 3'b111 || dmem_addr !== {a[31:2], 2'b00}
            || dmem_be !== exp_be || dmem_wdata !== exp_wdata) begin
            errors++;
            $display("FAIL %s_req: got req/we/stall=%b addr=%h be=%b wdata=%h want 111 addr=%h be=%b wdata=%h",
                     name, {dmem_req, dmem_we, stall}, dmem_addr, dmem_be, dmem_wdata,
                     {a[31:2], 2'b00}, exp_be, exp_wdata);
        end
        for (int i = 1; i < wait_cycles; i++) begin
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b1 || dmem_be !== exp_be || dmem_wdata !== exp_wdata || store_done !== 1'b0) begin
                errors++; $display("FAIL %s_hold%0d: got req=%b be=%b wdata=%h done=%b want 1 %b %h 0",
                                   name, i, dmem_req, dmem_be, dmem_wdata, store_done, exp_be, exp_wdata);
            end
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({dmem_req, store_done, load_valid, ls_ready} !== 4'b0100) begin
            errors++; $display("FAIL %s_done: got req/done/lv/ready=%b want 0100",
                               name, {dmem_req, store_done, load_valid, ls_ready});
        end
        @(negedge clk);
        checks++;
        if ({store_done, ls_ready} !== 2'b01) begin
            errors++; $display("FAIL %s_idle: got done/ready=%b want 01", name, {store_done, ls_ready});
        end
        $display("store %s: addr=%h be=%b wdata=%h", name, dmem_addr, dmem_be, dmem_wdata);
    endtask

    task automatic test_load(input string name, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] rd,
                             input logic [3:0] exp_be, input logic [31:0] exp_data);
        drive_req(1'b1, 1'b0, sz, uns, a, 32'h0);
        @(negedge clk);
        ls_valid = 1'b0;
        checks++;
        if ({dmem_req, dmem_we} !== 2'b10 || dmem_be !== exp_be || dmem_addr !== {a[31:2], 2'b00}) begin
            errors++; $display("FAIL %s_req: got req/we=%b be=%b addr=%h want 10 be=%b addr=%h",
                               name, {dmem_req, dmem_we}, dmem_be, dmem_addr, exp_be, {a[31:2], 2'b00});
        end
        dmem_ack = 1'b1; dmem_rdata = rd;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        checks++;
        if (load_valid !== 1'b1 || load_data !== exp_data || dmem_req !== 1'b0) begin
            errors++; $display("FAIL %s_data: got valid=%b data=%h req=%b want 1 %h 0",
                               name, load_valid, load_data, dmem_req, exp_data);
        end
        @(negedge clk);
        checks++;
        if ({load_valid, ls_ready} !== 2'b01) begin
            errors++; $display("FAIL %s_idle: got valid/ready=%b want 01", name, {load_valid, ls_ready});
        end
        $display("load %s: addr=%h rdata=%h -> %h", name, a, rd, load_data);
    endtask

    task automatic test_misaligned(input string name, input logic [1:0] sz, input logic [31:0] a);
        drive_req(1'b1, 1'b0, sz, 1'b0, a, 32'h0);
        @(negedge clk);
        ls_valid = 1'b0;
        checks++;
        if ({misaligned, dmem_req, ls_ready} !== 3'b101) begin
            errors++; $display("FAIL %s_pulse: got mis/req/ready=%b want 101", name, {misaligned, dmem_req, ls_ready});
        end
        @(negedge clk);
        checks++;
        if ({misaligned, dmem_req, ls_ready} !== 3'b001) begin
            errors++; $display("FAIL %s_after: got mis/req/ready=%b want 001", name, {misaligned, dmem_req, ls_ready});
        end
        $display("misaligned %s: addr=%h size=%b", name, a, sz);
    endtask

    task automatic test_timeout();
        // No ack: request must stay up for exactly 4 cycles.
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            ls_valid = 1'b0;
            checks++;
            if (dmem_req !== 1'b1 || bus_err !== 1'b0) begin
                errors++; $display("FAIL timeout_req%0d: got req=%b err=%b want 1 0", i, dmem_req, bus_err);
            end
        end
        @(negedge clk);
        checks++;
        if ({dmem_req, bus_err, load_valid} !== 3'b010) begin
            errors++; $display("FAIL timeout_err: got req/err/lv=%b want 010", {dmem_req, bus_err, load_valid});
        end
        @(negedge clk);
        checks++;
        if ({bus_err, ls_ready} !== 2'b01) begin
            errors++; $display("FAIL timeout_idle: got err/ready=%b want 01", {bus_err, ls_ready});
        end
        $display("timeout: bus error after 4 request cycles");
        // Ack in the 4th cycle wins over the timeout.
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            ls_valid = 1'b0;
        end
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h55AA33CC;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        checks++;
        if ({dmem_req, bus_err, load_valid} !== 3'b001 || load_data !== 32'h55AA33CC) begin
            errors++; $display("FAIL late_ack: got req/err/lv=%b data=%h want 001 55aa33cc",
                               {dmem_req, bus_err, load_valid}, load_data);
        end
        @(negedge clk);
        checks++;
        if ({bus_err, ls_ready} !== 2'b01) begin
            errors++; $display("FAIL late_ack_idle: got err/ready=%b want 01", {bus_err, ls_ready});
        end
        $display("timeout: ack in last cycle completes load data=%h", load_data);
    endtask

    task automatic test_flush();
        // Flush in IDLE blocks acceptance.
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        ls_valid = 1'b0; flush = 1'b0;
        checks++;
        if ({dmem_req, ls_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_idle: got req/ready=%b want 01", {dmem_req, ls_ready});
        end
        // Flush during BUSY: transaction completes but result is hidden.
        drive_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h54, 32'h0);
        @(negedge clk);
        ls_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL flush_busy_req: got req=%b want 1", dmem_req);
        end
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        checks++;
        if ({dmem_req, load_valid, bus_err, store_done} !== 4'b0000) begin
            errors++; $display("FAIL flush_busy_done: got req/lv/err/sd=%b want 0000",
                               {dmem_req, load_valid, bus_err, store_done});
        end
        @(negedge clk);
        checks++;
        if ({load_valid, ls_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_busy_idle: got lv/ready=%b want 01", {load_valid, ls_ready});
        end
        $display("flush: busy load completed silently");
    endtask

    task automatic test_back_to_back();
        // Valid held continuously: second access accepted 3 cycles after the first.
        drive_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h60, 32'h0);
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h000000F0;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({load_valid, ls_ready, dmem_req} !== 3'b100 || load_data !== 32'h000000F0) begin
            errors++; $display("FAIL b2b_first: got lv/ready/req=%b data=%h want 100 000000f0",
                               {load_valid, ls_ready, dmem_req}, load_data);
        end
        @(negedge clk);
        checks++;
        if ({ls_ready, dmem_req} !== 2'b10) begin
            errors++; $display("FAIL b2b_gap: got ready/req=%b want 10", {ls_ready, dmem_req});
        end
        @(negedge clk);
        ls_valid = 1'b0;
        checks++;
        if ({ls_ready, dmem_req} !== 2'b01) begin
            errors++; $display("FAIL b2b_second: got ready/req=%b want 01", {ls_ready, dmem_req});
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h000000F0;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        checks++;
        if (load_valid !== 1'b1 || load_data !== 32'h000000F0) begin
            errors++; $display("FAIL b2b_second_data: got lv=%b data=%h want 1 000000f0", load_valid, load_data);
        end
        @(negedge clk);
        $display("back_to_back: two loads 3 cycles apart");
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h70, 32'hCAFEF00D);
        @(negedge clk);
        ls_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got req=%b want 1", dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, ls_ready} !== 2'b01) begin
            errors++; $display("FAIL rst_mid_async: got req/ready=%b want 01", {dmem_req, ls_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ls_ready, dmem_req, load_valid, store_done, misaligned, bus_err} !== 6'b100000) begin
            errors++; $display("FAIL rst_mid_after: got %b want 100000",
                               {ls_ready, dmem_req, load_valid, store_done, misaligned, bus_err});
        end
        $display("reset_mid: request dropped asynchronously");
    endtask

    initial begin
        test_reset();
        test_store("sb_1003", 2'b00, 32'h00001003, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 2);
        test_store("sh_0010", 2'b01, 32'h00000010, 32'h1234BEEF, 4'b0011, 32'hBEEFBEEF, 1);
        test_store("sw_0020", 2'b10, 32'h00000020, 32'h01020304, 4'b1111, 32'h01020304, 1);
        test_load("lh_s",  2'b01, 1'b0, 32'h00002002, 32'h80011234, 4'b1100, 32'hFFFF8001);
        test_load("lhu",   2'b01, 1'b1, 32'h00002002, 32'h80011234, 4'b1100, 32'h00008001);
        test_load("lb_7f", 2'b00, 1'b0, 32'h00002001, 32'h00007F00, 4'b0010, 32'h0000007F);
        test_load("lb_80", 2'b00, 1'b0, 32'h00002003, 32'h80000000, 4'b1000, 32'hFFFFFF80);
        test_load("lhu_0", 2'b01, 1'b1, 32'h00002000, 32'h0000ABCD, 4'b0011, 32'h0000ABCD);
        test_load("lw",    2'b10, 1'b0, 32'h00002004, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        test_misaligned("lw_3001", 2'b10, 32'h00003001);
        test_misaligned("sz11",    2'b11, 32'h00003000);
        test_misaligned("lh_3003", 2'b01, 32'h00003003);
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory side of the core's load/store path. It consumes the memory-access controls the instruction decoder produces (load/store qualifier, size, unsigned flag) together with the effective address and store data from execute.
- It runs a request/acknowledge transaction on the data-memory port, generates byte enables and lane-replicated store data, and returns aligned, sign/zero-extended load data.
- It stalls the pipeline while a transaction is outstanding and reports misaligned-access and bus-timeout faults to trap logic.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for dmem_ack_in before a bus error is raised; must be at least 1.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- ls_valid_in  input  1  execute stage presents a memory instruction this cycle.
- is_load_in  input  1  access is a load.
- is_store_in  input  1  access is a store; is_load_in and is_store_in are never both 1.
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 illegal; applies to stores too.
- load_unsigned_in  input  1  zero-extend load data when 1, sign-extend when 0.
- addr_in  input  32  effective byte address.
- store_data_in  input  32  rs2 value.
- flush_in  input  1  trap/flush from the pipeline.
- ls_ready_out  output  1  unit idle and able to accept a request.
- stall_out  output  1  equals ~ls_ready_out.
- dmem_req_out  output  1  memory request, held until acknowledged.
- dmem_we_out  output  1  1 for a store request.
- dmem_addr_out  output  32  {addr[31:2], 2'b00}.
- dmem_be_out  output  4  byte enables.
- dmem_wdata_out  output  32  lane-replicated store data.
- dmem_ack_in  input  1  single-cycle acknowledge; for loads, read data is valid in the same cycle.
- dmem_rdata_in  input  32  read word.
- load_data_out  output  32  extended load result.
- load_valid_out  output  1  one-cycle pulse, load result valid.
- store_done_out  output  1  one-cycle pulse, store completed.
- misaligned_out  output  1  one-cycle pulse, misaligned or illegal-size access rejected.
- bus_err_out  output  1  one-cycle pulse, acknowledge timeout.

Behaviour:
- States: IDLE, BUSY.
- Reset: state IDLE; all outputs 0 except ls_ready_out=1; load_data_out=0; counter=0. Reset asserted mid-transaction drops dmem_req_out asynchronously.
- Accept condition (IDLE): ls_valid_in & (is_load_in|is_store_in) & ~flush_in.
- Fault check:
  - Fault if size=11, half with addr[0]=1, or word with addr[1:0]!=00.
  - On fault: no request, stay IDLE, misaligned_out=1 in the next cycle.
- Accepted and not faulted:
  - Register address, be, wdata, we, size, unsigned flag and byte offset.
  - Enter BUSY; dmem_req_out=1 from the next cycle (registered, 1-cycle latency).
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
- BUSY, request side:
  - dmem_req_out and all dmem_* outputs are held stable until dmem_ack_in.
  - Counter increments each BUSY cycle without ack.
- BUSY, ack received:
  - Drop request and return to IDLE on the next edge; counter cleared.
  - Load: load_data_out/load_valid_out registered from dmem_rdata_in (valid the cycle after ack).
  - Store: store_done_out pulses the cycle after ack.
- Load extraction:
  - byte = rdata[8*off +: 8]; half = rdata[16*off[1] +: 16].
  - Extend to 32 using bit 7/15 unless unsigned.
- Timeout: if counter reaches TIMEOUT_CYCLES-1 with no ack, drop the request, pulse bus_err_out next cycle, go IDLE. An ack arriving in the same cycle takes priority over timeout.
- flush_in:
  - In IDLE, it blocks acceptance.
  - In BUSY, the request is not cancelled; it completes or times out. A flush_pending flag suppresses load_valid_out/store_done_out/bus_err_out of that transaction and is cleared on return to IDLE.
- ls_valid_in while BUSY is ignored; the pipeline is stalled.
- Back-to-back accesses: earliest acceptance is the cycle after the return to IDLE, giving a minimum of 3 cycles per access with an immediate ack.

Decomposition:
- Shared package, defining:
  - size encodings LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10;
  - state encoding;
  - default TIMEOUT_CYCLES.
- One combinational sub-module, load_align_ext: takes offset, size, unsigned flag and rdata; returns the extended 32-bit result. Reused by any future bus-master path.

Test Plan:
- Store byte, addr=0x1003, data=0x000000A5, ack after 2 cycles -> dmem_addr_out=0x1000, be=1000, wdata=0xA5A5A5A5, req held 2 cycles, store_done_out pulse 1 cycle after ack.
- Load half signed, addr=0x2002, rdata=0x8001_1234 -> load_data_out=0xFFFF8001; same access unsigned -> 0x00008001; byte at offset 1 of 0x00_00_7F_00 signed -> 0x0000007F.
- Load word at addr=0x3001 -> no dmem_req_out, misaligned_out pulse next cycle, ls_ready_out stays 1; size=11 at addr=0x3000 -> same response.
- TIMEOUT_CYCLES=4, no ack -> req high exactly 4 cycles, bus_err_out pulse, back to IDLE; repeat with ack in cycle 4 -> completion, no bus_err_out.
- Load accepted, flush_in during BUSY, ack 3 cycles later -> transaction completes on port, load_valid_out stays 0, unit ready afterwards.
- rst_n_in low while req high -> dmem_req_out falls immediately; after release ls_ready_out=1 and all pulses 0.
